// File: rtl/edg_pair_sched_pkg.sv
// Shared types for the edge-detection pair scheduler.
// Holds FSM states, default widths and the tag/result bundles.
package edg_sched_pkg;

    localparam int EDG_PIX_W  = 36;
    localparam int EDG_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  src;
        logic [EDG_ADDR_W-1:0] addr;
    } tag_t;

    typedef struct packed {
        logic [EDG_PIX_W-1:0]  pix;
        logic [EDG_ADDR_W-1:0] addr;
        logic                  src;
    } res_t;

endpackage

// File: rtl/edg_res_fifo.sv
// Result FIFO: DEPTH-entry synchronous queue with occupancy count.
// Head data reads as zero while the queue is empty.
module edg_res_fifo #(
    parameter int W     = 56,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rp];

endmodule

// File: rtl/edg_pair_sched.sv
// Edge-detection pair scheduler: 2-cycle slot issue, RR arbitration,
// latency tag pipe and credit-protected result FIFO. Option: EDG_BYPASS_EN.
module edg_pair_sched
    import edg_sched_pkg::*;
#(
    parameter int PIX_W     = EDG_PIX_W,
    parameter int ADDR_W    = EDG_ADDR_W,
    parameter int LAT_SLOTS = 2,
    parameter int DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              gs_switch,
`ifdef EDG_BYPASS_EN
    input  logic              bypass,
`endif
    input  logic              req0_valid,
    input  logic [PIX_W-1:0]  req0_pix,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [PIX_W-1:0]  req1_pix,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [PIX_W-1:0]  edg_pix,
    output logic              edg_phase,
    output logic              edg_gs,
    input  logic [PIX_W-1:0]  edg_result,
    output logic              res_valid,
    output logic [PIX_W-1:0]  res_pix,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_src,
    input  logic              res_ready,
    output logic              busy
);
    localparam int IW = $clog2(LAT_SLOTS + 1);

    state_t                 state_q, state_d;
    logic                   phase_q, gs_q, rr_q, gs_load;
    logic [PIX_W-1:0]       pix_q, issue_pix, cap_pix;
    logic [ADDR_W-1:0]      issue_addr;
    tag_t                   tags_q [LAT_SLOTS];
    logic [IW-1:0]          inflight;
    logic                   credit_ok, slot_open;
    logic                   gnt0, gnt1, issue;
    logic                   push, pop, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;
    res_t                   push_data, head;

    // Count tags still travelling through the datapath
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT_SLOTS; i++)
            inflight = inflight + IW'(tags_q[i].valid);
    end

    assign credit_ok = (int'(fifo_cnt) + int'(inflight)) < DEPTH;
    assign slot_open = (state_q == RUN) && !phase_q && credit_ok;

    // Frame FSM next state and gs/bypass latch enable
    always_comb begin
        state_d = state_q;
        gs_load = 1'b0;
        unique case (state_q)
            IDLE: if (frame_start) begin
                state_d = RUN;
                gs_load = 1'b1;
            end
            RUN: if (frame_start) begin
                if (inflight != '0) state_d = DRAIN;
                else                gs_load = 1'b1;
            end
            DRAIN: if (inflight == '0) begin
                state_d = RUN;
                gs_load = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin grant for the open issue slot
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (slot_open) begin
            unique case (1'b1)
                req0_valid && req1_valid: begin
                    gnt0 = !rr_q;
                    gnt1 = rr_q;
                end
                req0_valid && !req1_valid: gnt0 = 1'b1;
                !req0_valid && req1_valid: gnt1 = 1'b1;
                default: ;
            endcase
        end
    end

    assign issue      = gnt0 || gnt1;
    assign issue_pix  = gnt1 ? req1_pix : req0_pix;
    assign issue_addr = gnt1 ? req1_addr : req0_addr;

    // FSM, phase, frame config, RR pointer and datapath pair register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            gs_q    <= 1'b0;
            rr_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= (state_q == IDLE) ? 1'b0 : !phase_q;
            if (gs_load) gs_q <= gs_switch;
            if (issue) begin
                pix_q <= issue_pix;
                rr_q  <= !gnt1;
            end
        end
    end

    // Tag pipe shadows the datapath latency, one step per slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT_SLOTS; i++) tags_q[i] <= '0;
        end else if (!phase_q) begin
            tags_q[0] <= '{valid: issue, src: gnt1, addr: issue_addr};
            for (int i = 1; i < LAT_SLOTS; i++) tags_q[i] <= tags_q[i-1];
        end
    end

`ifdef EDG_BYPASS_EN
    logic             byp_q;
    logic [PIX_W-1:0] dly_q [LAT_SLOTS];

    // Raw copy of each issued pair, aligned with its tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_q <= 1'b0;
            for (int i = 0; i < LAT_SLOTS; i++) dly_q[i] <= '0;
        end else begin
            if (gs_load) byp_q <= bypass;
            if (!phase_q) begin
                dly_q[0] <= issue_pix;
                for (int i = 1; i < LAT_SLOTS; i++) dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign cap_pix = byp_q ? dly_q[LAT_SLOTS-1] : edg_result;
`else
    assign cap_pix = edg_result;
`endif

    assign push      = !phase_q && tags_q[LAT_SLOTS-1].valid;
    assign pop       = !fifo_empty && res_ready;
    assign push_data = '{pix:  cap_pix,
                         addr: tags_q[LAT_SLOTS-1].addr,
                         src:  tags_q[LAT_SLOTS-1].src};

    edg_res_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign edg_pix    = pix_q;
    assign edg_phase  = phase_q;
    assign edg_gs     = gs_q;
    assign res_valid  = !fifo_empty;
    assign res_pix    = head.pix;
    assign res_addr   = head.addr;
    assign res_src    = head.src;
    assign busy       = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_edg_pair_sched.sv
// Randomised bench for edg_pair_sched against a queue-based model.
// Build with EDG_BYPASS_EN to also exercise the bypass path.
module tb_edg_pair_sched;
    localparam int PIX_W  = 36;
    localparam int ADDR_W = 19;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_start = 1'b0;
    logic              gs_switch = 1'b0;
`ifdef EDG_BYPASS_EN
    logic              bypass = 1'b0;
`endif
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic [PIX_W-1:0]  req0_pix = '0, req1_pix = '0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic              req0_ready, req1_ready;
    logic [PIX_W-1:0]  edg_pix;
    logic              edg_phase, edg_gs;
    logic [PIX_W-1:0]  edg_result = '0;
    logic              res_valid;
    logic [PIX_W-1:0]  res_pix;
    logic [ADDR_W-1:0] res_addr;
    logic              res_src;
    logic              res_ready = 1'b0;
    logic              busy;

    always #5 clk = ~clk;

    edg_pair_sched #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .LAT_SLOTS(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .frame_start(frame_start), .gs_switch(gs_switch),
`ifdef EDG_BYPASS_EN
        .bypass(bypass),
`endif
        .req0_valid(req0_valid), .req0_pix(req0_pix),
        .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_pix(req1_pix),
        .req1_addr(req1_addr), .req1_ready(req1_ready),
        .edg_pix(edg_pix), .edg_phase(edg_phase), .edg_gs(edg_gs),
        .edg_result(edg_result),
        .res_valid(res_valid), .res_pix(res_pix),
        .res_addr(res_addr), .res_src(res_src),
        .res_ready(res_ready), .busy(busy)
    );

    // model: in-flight issues (with issue cycle) and queued results
    typedef struct {
        int                t;
        bit                src;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  pix;
    } fl_t;
    typedef struct {
        logic [PIX_W-1:0]  pix;
        logic [ADDR_W-1:0] addr;
        bit                src;
    } rs_t;

    fl_t fl[$];
    rs_t fq[$];
    int  m_st;   // 0 stopped, 1 running, 2 draining
    bit  m_ph, m_gs, m_rr, m_byp;
    logic [PIX_W-1:0] m_pix;
    int  cyc = 0;
    bit  g0, g1;
    logic d0, d1, d_rv;
    int  d_cyc;
    int  n_chk = 0, n_pass = 0;

    function automatic logic [PIX_W-1:0] rpix();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PIX_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] raddr();
        logic [31:0] r;
        r = $urandom;
        return r[ADDR_W-1:0];
    endfunction

    task automatic model_clear();
        fl.delete();
        fq.delete();
        m_st = 0; m_ph = 0; m_gs = 0; m_rr = 0; m_byp = 0; m_pix = '0;
    endtask

    // one clock: compare against model, advance model across the edge
    task automatic step();
        bit so, byp_in;
        int nin, old;
        logic ev, es, eb;
        logic [PIX_W-1:0] ep;
        logic [ADDR_W-1:0] ea;
        #1;
        nin = fl.size();
        so = (m_st == 1) && !m_ph && (DEPTH - fq.size() - nin > 0);
        g0 = so && req0_valid && (!req1_valid || !m_rr);
        g1 = so && req1_valid && (!req0_valid || m_rr);
        ev = fq.size() != 0;
        ep = ev ? fq[0].pix : '0;
        ea = ev ? fq[0].addr : '0;
        es = ev ? fq[0].src : 1'b0;
        eb = (nin != 0) || ev;
        d0 = req0_ready; d1 = req1_ready; d_rv = res_valid; d_cyc = cyc;
        n_chk++; if (edg_phase !== m_ph) $display("FAIL phase cyc=%0d got=%b exp=%b", cyc, edg_phase, m_ph); else n_pass++;
        n_chk++; if (edg_gs !== m_gs) $display("FAIL gs cyc=%0d got=%b exp=%b", cyc, edg_gs, m_gs); else n_pass++;
        n_chk++; if (req0_ready !== g0) $display("FAIL ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready, g0); else n_pass++;
        n_chk++; if (req1_ready !== g1) $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready, g1); else n_pass++;
        n_chk++; if (res_valid !== ev) $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid, ev); else n_pass++;
        n_chk++;
        if ({res_pix, res_addr, res_src} !== {ep, ea, es})
            $display("FAIL res_data cyc=%0d got=%h/%0d/%b exp=%h/%0d/%b", cyc, res_pix, res_addr, res_src, ep, ea, es);
        else n_pass++;
        n_chk++; if (busy !== eb) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb); else n_pass++;
        n_chk++; if (edg_pix !== m_pix) $display("FAIL edg_pix cyc=%0d got=%h exp=%h", cyc, edg_pix, m_pix); else n_pass++;
        byp_in = 0;
`ifdef EDG_BYPASS_EN
        byp_in = bypass;
`endif
        @(posedge clk);
        if (ev && res_ready) void'(fq.pop_front());
        if (nin != 0 && fl[0].t + 2 * LAT == cyc) begin
            fq.push_back('{pix: m_byp ? fl[0].pix : edg_result, addr: fl[0].addr, src: fl[0].src});
            void'(fl.pop_front());
        end
        if (g0 || g1) begin
            fl.push_back('{t: cyc, src: g1,
                           addr: g1 ? req1_addr : req0_addr,
                           pix: g1 ? req1_pix : req0_pix});
            m_pix = g1 ? req1_pix : req0_pix;
            m_rr = !g1;
        end
        old = m_st;
        if (m_st == 0) begin
            if (frame_start) begin m_st = 1; m_gs = gs_switch; m_byp = byp_in; end
        end else if (m_st == 1) begin
            if (frame_start) begin
                if (nin != 0) m_st = 2;
                else begin m_gs = gs_switch; m_byp = byp_in; end
            end
        end else if (nin == 0) begin
            m_st = 1; m_gs = gs_switch; m_byp = byp_in;
        end
        m_ph = (old == 0) ? 1'b0 : !m_ph;
        cyc++;
        @(negedge clk);
        edg_result = rpix();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_ready got=%b exp=00", {req0_ready, req1_ready}); else n_pass++;
        n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got=%b exp=0", res_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if ({edg_phase, edg_gs} !== 2'b00) $display("FAIL rst_phase_gs got=%b exp=00", {edg_phase, edg_gs}); else n_pass++;
        n_chk++; if (edg_pix !== '0) $display("FAIL rst_edg_pix got=%h exp=0", edg_pix); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1;
        repeat (3) step();
        req0_valid = 1'b0;
    endtask

    task automatic test_basic();
        int t_run, t_iss, t_res;
        res_ready = 1'b1; gs_switch = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0; gs_switch = 1'b0;
        t_run = cyc;
        n_chk++; if (edg_gs !== 1'b1) $display("FAIL basic_gs got=%b exp=1", edg_gs); else n_pass++;
        req0_valid = 1'b1; req0_pix = 36'h0_0003F_FFF; req0_addr = 19'd5;
        t_iss = -1;
        for (int i = 0; i < 6 && t_iss < 0; i++) begin
            step();
            if (d0 === 1'b1) t_iss = d_cyc;
        end
        req0_valid = 1'b0;
        n_chk++; if (t_iss !== t_run) $display("FAIL basic_issue_cycle got=%0d exp=%0d", t_iss, t_run); else n_pass++;
        t_res = -1;
        for (int i = 0; i < 12 && t_res < 0; i++) begin
            step();
            if (d_rv === 1'b1) t_res = d_cyc;
        end
        n_chk++;
        if (t_res < 0 || t_res - t_iss != 2 * LAT + 1)
            $display("FAIL basic_latency got=%0d exp=%0d", t_res - t_iss, 2 * LAT + 1);
        else n_pass++;
    endtask

    task automatic test_rr();
        int last, n;
        res_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_pix = rpix(); req1_pix = rpix();
        req0_addr = raddr(); req1_addr = raddr();
        last = -1; n = 0;
        repeat (40) begin
            step();
            if (d0 === 1'b1 || d1 === 1'b1) begin
                n++;
                if (last >= 0) begin
                    n_chk++;
                    if (int'(d1) == last) $display("FAIL rr_alternate got=%0d exp=%0d", d1, 1 - last);
                    else n_pass++;
                end
                last = int'(d1);
            end
            if (d0 === 1'b1) begin req0_pix = rpix(); req0_addr = raddr(); end
            if (d1 === 1'b1) begin req1_pix = rpix(); req1_addr = raddr(); end
        end
        n_chk++; if (n != 20) $display("FAIL rr_grant_count got=%0d exp=20", n); else n_pass++;
    endtask

    task automatic test_stall();
        int n;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        repeat (12) step();
        res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        repeat (30) begin
            step();
            if (d0 === 1'b1) begin n++; req0_pix = rpix(); req0_addr = raddr(); end
            if (d1 === 1'b1) begin n++; req1_pix = rpix(); req1_addr = raddr(); end
        end
        n_chk++; if (n != DEPTH) $display("FAIL stall_accepts got=%0d exp=%0d", n, DEPTH); else n_pass++;
        res_ready = 1'b1;
        n = 0;
        repeat (30) begin
            step();
            if (d0 === 1'b1) begin n++; req0_pix = rpix(); req0_addr = raddr(); end
            if (d1 === 1'b1) begin n++; req1_pix = rpix(); req1_addr = raddr(); end
        end
        n_chk++; if (n == 0) $display("FAIL stall_resume got=%0d exp=>0", n); else n_pass++;
    endtask

    task automatic test_drain();
        int n;
        logic gs_new;
        res_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12 && fl.size() != 2; i++) step();
        gs_new = !m_gs;
        gs_switch = gs_new; frame_start = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 12 && m_st == 2; i++) begin
            frame_start = (i == 0);
            step();
            if (d0 === 1'b1 || d1 === 1'b1) n++;
        end
        frame_start = 1'b0;
        n_chk++; if (n != 0) $display("FAIL drain_ready got=%0d exp=0", n); else n_pass++;
        n_chk++; if (edg_gs !== gs_new) $display("FAIL drain_gs got=%b exp=%b", edg_gs, gs_new); else n_pass++;
        repeat (6) step();
    endtask

    task automatic test_mid_reset();
        int n;
        res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 20 && fq.size() < 3; i++) step();
        #2 reset = 1'b0;
        #1;
        n_chk++; if ({res_valid, busy} !== 2'b00) $display("FAIL mrst_valid_busy got=%b exp=00", {res_valid, busy}); else n_pass++;
        n_chk++; if ({req0_ready, req1_ready, edg_phase, edg_gs} !== 4'b0) $display("FAIL mrst_ctrl got=%b exp=0000", {req0_ready, req1_ready, edg_phase, edg_gs}); else n_pass++;
        n_chk++; if ({edg_pix, res_pix} !== '0) $display("FAIL mrst_pix got=%h/%h exp=0", edg_pix, res_pix); else n_pass++;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        n = 0;
        repeat (10) begin
            step();
            if (d_rv !== 1'b0) n++;
        end
        n_chk++; if (n != 0) $display("FAIL mrst_stale got=%0d exp=0", n); else n_pass++;
    endtask

    task automatic test_random();
        repeat (400) begin
            req0_valid = ($urandom_range(3, 0) != 0);
            req1_valid = ($urandom_range(3, 0) != 0);
            if (req0_valid) begin req0_pix = rpix(); req0_addr = raddr(); end
            if (req1_valid) begin req1_pix = rpix(); req1_addr = raddr(); end
            frame_start = ($urandom_range(39, 0) == 0);
            gs_switch = ($urandom_range(1, 0) == 1);
            res_ready = ($urandom_range(9, 0) < 7);
            step();
        end
        frame_start = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        repeat (12) step();
    endtask

`ifdef EDG_BYPASS_EN
    task automatic test_bypass();
        int t_iss, t_res;
        logic [PIX_W-1:0] got;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        bypass = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0; bypass = 1'b0;
        req0_valid = 1'b1; req0_pix = 36'h123456789; req0_addr = 19'd9;
        t_iss = -1;
        for (int i = 0; i < 6 && t_iss < 0; i++) begin
            step();
            if (d0 === 1'b1) t_iss = d_cyc;
        end
        req0_valid = 1'b0;
        t_res = -1; got = '0;
        for (int i = 0; i < 12 && t_res < 0; i++) begin
            #1 got = res_pix;
            step();
            if (d_rv === 1'b1) t_res = d_cyc;
        end
        n_chk++; if (got !== 36'h123456789) $display("FAIL byp_pix got=%h exp=123456789", got); else n_pass++;
        n_chk++;
        if (t_res < 0 || t_res - t_iss != 2 * LAT + 1)
            $display("FAIL byp_latency got=%0d exp=%0d", t_res - t_iss, 2 * LAT + 1);
        else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_rr();
        test_stall();
        test_drain();
        test_mid_reset();
        test_random();
`ifdef EDG_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
